// File: rtl/mem_arbiter.sv
// mem_arbiter: owns the unified main memory and sequences every access to it.
// Serves D-cache write-through stores, D-cache block fills and I-cache block
// fills under fixed priority (store > D fill > I fill). A fill issues WORDS
// consecutive word reads of the aligned block and steers each returned word
// into the requesting cache.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   i_miss, i_miss_addr         I-cache fill request (level) and byte address
//   d_miss, d_miss_addr         D-cache fill request (level) and byte address
//   d_wr_req, d_wr_addr/_data   store request (level), byte address, data
//   mem_en, mem_wr              memory strobe, 1 = write / 0 = read
//   mem_addr, mem_wdata         memory byte address and write data
//   mem_rdata, mem_rvalid       read data beat from memory (fixed latency)
//   fill_we, fill_sel           cache fill write strobe, 0 = I-cache / 1 = D-cache
//   fill_word, fill_data        word index within block, returned data
//   i_done, d_done, wr_done     one-cycle completion pulses
//   busy                        operation in progress or post-reset quiet period
module mem_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8,
  parameter int DATA_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_miss,
  input  logic [DATA_W-1:0]        i_miss_addr,
  input  logic                     d_miss,
  input  logic [DATA_W-1:0]        d_miss_addr,
  input  logic                     d_wr_req,
  input  logic [DATA_W-1:0]        d_wr_addr,
  input  logic [DATA_W-1:0]        d_wr_data,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [DATA_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_rvalid,
  output logic                     fill_we,
  output logic                     fill_sel,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic [DATA_W-1:0]        fill_data,
  output logic                     i_done,
  output logic                     d_done,
  output logic                     wr_done,
  output logic                     busy
);

  localparam int WIDX_W = $clog2(WORDS);
  localparam int CNT_W  = $clog2(WORDS + 1);
  localparam int QW     = $clog2(MEM_LAT + 1);

  localparam logic [CNT_W-1:0]  ISSUE_END  = CNT_W'(WORDS);
  localparam logic [WIDX_W-1:0] BEAT_LAST  = WIDX_W'(WORDS - 1);
  // Block is WORDS 16-bit words; clear the byte-offset bits of the block.
  localparam logic [DATA_W-1:0] BLOCK_MASK = ~DATA_W'(2 * WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    issue_q, issue_d;
  logic [WIDX_W-1:0]   beat_q,  beat_d;
  logic                sel_q,   sel_d;
  logic [QW-1:0]       quiet_q, quiet_d;
  logic [DATA_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                quiet_active;

  // Reads issued before a reset may still return during the quiet period;
  // requests and beats are ignored until it has drained.
  assign quiet_active = (quiet_q != '0);
  assign busy         = (state_q != IDLE) || quiet_active;
  assign fill_data    = mem_rdata;

  always_comb begin
    state_d   = state_q;
    issue_d   = issue_q;
    beat_d    = beat_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    quiet_d   = quiet_active ? quiet_q - QW'(1) : quiet_q;

    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_we   = 1'b0;
    fill_word = beat_q;
    fill_sel  = sel_q;
    i_done    = 1'b0;
    d_done    = 1'b0;
    wr_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!quiet_active) begin
          if (d_wr_req) begin
            addr_d  = d_wr_addr;
            wdata_d = d_wr_data;
            state_d = WRITE;
          end else if (d_miss) begin
            addr_d  = d_miss_addr & BLOCK_MASK;
            sel_d   = 1'b1;
            issue_d = '0;
            beat_d  = '0;
            state_d = FILL;
          end else if (i_miss) begin
            addr_d  = i_miss_addr & BLOCK_MASK;
            sel_d   = 1'b0;
            issue_d = '0;
            beat_d  = '0;
            state_d = FILL;
          end
        end
      end

      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        wr_done   = 1'b1;
        state_d   = IDLE;
      end

      FILL: begin
        // Issue and return phases overlap: reads keep going out while the
        // first beats are already coming back.
        if (issue_q != ISSUE_END) begin
          mem_en   = 1'b1;
          mem_addr = addr_q + (DATA_W'(issue_q) << 1);
          issue_d  = issue_q + CNT_W'(1);
        end
        if (mem_rvalid) begin
          fill_we = 1'b1;
          beat_d  = (beat_q == BEAT_LAST) ? '0 : beat_q + WIDX_W'(1);
          if (beat_q == BEAT_LAST) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        i_done  = ~sel_q;
        d_done  = sel_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Reset aborts whatever is in flight: nothing reaches memory or a cache.
    if (rst) begin
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      fill_we   = 1'b0;
      fill_word = '0;
      fill_sel  = 1'b0;
      i_done    = 1'b0;
      d_done    = 1'b0;
      wr_done   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      issue_q <= '0;
      beat_q  <= '0;
      sel_q   <= 1'b0;
      quiet_q <= QW'(MEM_LAT);
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      beat_q  <= beat_d;
      sel_q   <= sel_d;
      quiet_q <= quiet_d;
    end
  end

  // Latched request address/data only matter once a state uses them.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: exercises mem_arbiter with directed and randomized request
// mixes against a fixed-latency memory model. Expected memory writes, reads,
// fill beats and done pulses (with their cycle numbers) are derived from the
// service order and timing rules, queued, and compared as the DUT emits them.
module tb_mem_arbiter;
  localparam int MEM_LAT = 4;
  localparam int WORDS   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid, mem_rv_model, inject;
  logic        fill_we, fill_sel;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        i_done, d_done, wr_done, busy;

  assign mem_rvalid = mem_rv_model | inject;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .WORDS(WORDS), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_we(fill_we), .fill_sel(fill_sel), .fill_word(fill_word), .fill_data(fill_data),
    .i_done(i_done), .d_done(d_done), .wr_done(wr_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [15:0] a; logic [15:0] d; } acc_t;
  typedef struct { int cyc; logic sel; logic [2:0] w; logic [15:0] d; } fill_t;
  typedef struct { int cyc; logic sel; } done_t;

  acc_t  wr_q[$];
  acc_t  rd_q[$];
  acc_t  pend_q[$];
  fill_t fill_q[$];
  done_t done_q[$];

  int n_tot  = 0;
  int n_pass = 0;

  function automatic logic [15:0] memval(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input bit ok,
                     input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // Memory: every read seen in cycle c returns in cycle c+MEM_LAT.
  initial begin
    mem_rv_model = 1'b0;
    mem_rdata    = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (pend_q.size() > 0 && pend_q[0].cyc == cyc) begin
        mem_rv_model = 1'b1;
        mem_rdata    = pend_q[0].d;
        void'(pend_q.pop_front());
      end else begin
        mem_rv_model = 1'b0;
        mem_rdata    = 16'($urandom);
      end
      @(negedge clk);
      if (mem_en && !mem_wr)
        pend_q.push_back('{cyc + MEM_LAT, mem_addr, memval(mem_addr)});
    end
  end

  // Monitor: every DUT event must match the head of its expectation queue.
  initial begin
    acc_t  e;
    fill_t f;
    done_t dn;
    forever begin
      @(negedge clk);
      if (mem_en && mem_wr) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 1'b0, {cyc, mem_addr, mem_wdata}, 64'h0);
        end else begin
          e = wr_q.pop_front();
          chk("mem_write", {cyc, mem_addr, mem_wdata} == {e.cyc, e.a, e.d},
              {cyc, mem_addr, mem_wdata}, {e.cyc, e.a, e.d});
          chk("wr_done_with_write", wr_done, 64'(wr_done), 64'h1);
        end
      end
      if (wr_done && !(mem_en && mem_wr))
        chk("stray_wr_done", 1'b0, {cyc, 32'h1}, {cyc, 32'h0});
      if (mem_en && !mem_wr) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_read", 1'b0, {cyc, mem_addr, 16'h0}, 64'h0);
        end else begin
          e = rd_q.pop_front();
          chk("mem_read", {cyc, mem_addr} == {e.cyc, e.a},
              {cyc, mem_addr, 16'h0}, {e.cyc, e.a, 16'h0});
        end
      end
      if (fill_we) begin
        if (fill_q.size() == 0) begin
          chk("unexpected_fill", 1'b0, {cyc, 12'h0, fill_sel, fill_word, fill_data}, 64'h0);
        end else begin
          f = fill_q.pop_front();
          chk("fill_beat",
              {cyc, 12'h0, fill_sel, fill_word, fill_data} == {f.cyc, 12'h0, f.sel, f.w, f.d},
              {cyc, 12'h0, fill_sel, fill_word, fill_data}, {f.cyc, 12'h0, f.sel, f.w, f.d});
        end
      end
      if (i_done || d_done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 1'b0, {cyc, 30'h0, d_done, i_done}, 64'h0);
        end else begin
          dn = done_q.pop_front();
          chk("fill_done", {cyc, 30'h0, d_done, i_done} == {dn.cyc, 30'h0, dn.sel, ~dn.sel},
              {cyc, 30'h0, d_done, i_done}, {dn.cyc, 30'h0, dn.sel, ~dn.sel});
        end
      end
    end
  end

  // Expected traffic of one fill whose request is sampled in IDLE cycle t.
  task automatic push_fill(input logic sel, input logic [15:0] addr, input int t,
                           input int nrd, input int nbeat, input bit with_done);
    logic [15:0] base;
    base = addr & 16'hFFF0;
    for (int k = 0; k < nrd; k++)
      rd_q.push_back('{t + 1 + k, base + 16'(2 * k), 16'h0});
    for (int k = 0; k < nbeat; k++)
      fill_q.push_back('{t + 1 + MEM_LAT + k, sel, 3'(k), memval(base + 16'(2 * k))});
    if (with_done)
      done_q.push_back('{t + WORDS + MEM_LAT + 1, sel});
  endtask

  // Raise a set of simultaneous requests first sampled in cycle s0; service
  // order is store, then D fill, then I fill, each starting in the next IDLE.
  task automatic issue(input bit w, input bit dm, input bit im,
                       input logic [15:0] wa, input logic [15:0] wd,
                       input logic [15:0] da, input logic [15:0] ia,
                       input bit inj, input int s0);
    int t;
    t = s0;
    if (w) begin
      wr_q.push_back('{t + 1, wa, wd});
      t += 2;
    end
    if (dm) begin
      push_fill(1'b1, da, t, WORDS, WORDS, 1'b1);
      t += WORDS + MEM_LAT + 2;
    end
    if (im) begin
      push_fill(1'b0, ia, t, WORDS, WORDS, 1'b1);
      t += WORDS + MEM_LAT + 2;
    end
    d_wr_addr   = wa;
    d_wr_data   = wd;
    d_miss_addr = da;
    i_miss_addr = ia;
    d_wr_req    = w;
    d_miss      = dm;
    i_miss      = im;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      // A spurious beat across the IDLE and WRITE cycles of a store.
      inject = inj && (c == 0);
      if (wr_done) d_wr_req = 1'b0;
      if (d_done)  d_miss   = 1'b0;
      if (i_done)  i_miss   = 1'b0;
      if (!(d_wr_req || d_miss || i_miss)) break;
    end
    inject = 1'b0;
    chk("requests_served", !(d_wr_req || d_miss || i_miss),
        {61'h0, d_wr_req, d_miss, i_miss}, 64'h0);
  endtask

  task automatic wait_idle();
    @(posedge clk);
    #1;
    for (int c = 0; c < 200 && busy; c++) begin
      @(posedge clk);
      #1;
    end
    chk("reach_idle", !busy, 64'(busy), 64'h0);
  endtask

  function automatic logic [63:0] out_vec();
    return {mem_addr, mem_wdata, 21'h0, mem_en, mem_wr, fill_we, i_done, d_done,
            wr_done, fill_sel, fill_word, busy};
  endfunction

  initial begin
    int cnt;
    int s0;
    logic [2:0] mask;
    rst = 1'b1;
    inject = 1'b0;
    i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
    i_miss_addr = 16'h0; d_miss_addr = 16'h0; d_wr_addr = 16'h0; d_wr_data = 16'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", out_vec() == 64'h1, out_vec(), 64'h1);
    @(posedge clk);
    #1 rst = 1'b0;

    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    chk("quiet_busy_cycles", cnt == MEM_LAT, 64'(cnt), 64'(MEM_LAT));

    wait_idle();
    issue(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h1236, 1'b0, cyc);
    wait_idle();
    issue(1'b1, 1'b0, 1'b0, 16'h0040, 16'hBEEF, 16'h0, 16'h0, 1'b1, cyc);
    wait_idle();
    issue(1'b1, 1'b1, 1'b1, 16'h0102, 16'h1234, 16'h4568, 16'hABCD, 1'b0, cyc);

    // Abort an I fill after three beats; reads k=7 and later never appear.
    wait_idle();
    s0 = cyc;
    push_fill(1'b0, 16'h3456, s0, WORDS - 1, 3, 1'b0);
    i_miss_addr = 16'h3456;
    i_miss = 1'b1;
    repeat (WORDS) @(posedge clk);
    #1;
    rst = 1'b1;
    i_miss = 1'b0;
    @(negedge clk);
    chk("abort_reset_outputs", out_vec() == 64'h1, out_vec(), 64'h1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_flushed", (rd_q.size() + fill_q.size() + done_q.size()) == 0,
        64'(rd_q.size() + fill_q.size() + done_q.size()), 64'h0);
    // Raised immediately: ignored until the quiet period ends.
    issue(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h2000, 16'h0, 1'b0, cyc + MEM_LAT);

    for (int n = 0; n < 25; n++) begin
      wait_idle();
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      mask = 3'($urandom_range(1, 7));
      issue(mask[2], mask[1], mask[0], 16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom), mask[2] && ($urandom_range(0, 1) == 1), cyc);
    end

    wait_idle();
    chk("all_drained",
        (wr_q.size() + rd_q.size() + fill_q.size() + done_q.size()) == 0,
        64'(wr_q.size() + rd_q.size() + fill_q.size() + done_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared-memory arbiter and miss-fill sequencer for the pipelined 16-bit CPU. It owns the single unified main memory, which has a fixed read latency. It arbitrates among three requests: I-cache block fills, D-cache block fills, and D-cache write-through stores. For a fill it issues the eight word reads of a 16-byte block and steers the returned words into the requesting cache. Miss detection and stall generation stay in the caches and pipeline control; this block only sequences memory.

## Interface
- MEM_LAT, 4, cycles from a read issue (mem_en=1, mem_wr=0) to its mem_rvalid beat
- WORDS, 8, words per cache block (block = 16 bytes)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_miss  in  1  I-cache fill request, level, held until i_done
- i_miss_addr  in  16  I-cache miss byte address
- d_miss  in  1  D-cache fill request, level, held until d_done
- d_miss_addr  in  16  D-cache miss byte address
- d_wr_req  in  1  store request, level, held until wr_done
- d_wr_addr  in  16  store byte address
- d_wr_data  in  16  store data
- mem_en  out  1  memory access strobe
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data
- mem_rvalid  in  1  mem_rdata valid
- fill_we  out  1  write fill_data into the selected cache
- fill_sel  out  1  0 = I-cache, 1 = D-cache
- fill_word  out  3  word index within the block
- fill_data  out  16  equals mem_rdata
- i_done, d_done, wr_done  out  1  one-cycle completion pulses
- busy  out  1  high whenever state != IDLE or the quiet counter is nonzero

## Operation
- States: IDLE, WRITE, FILL, DONE.
- Reset: state=IDLE, issue and beat counters=0, fill_sel=0, and the quiet counter is loaded with MEM_LAT.
- Reset output values: all outputs 0, except busy=1 while quiet is nonzero. mem_en, fill_we and the done pulses are forced 0 while rst=1.
- Quiet counter: decrements each cycle to 0. While it is nonzero, requests and mem_rvalid are ignored. This keeps stale in-flight reads issued before reset from landing in a new fill.
- IDLE arbitration, fixed priority d_wr_req > d_miss > i_miss. The winner's address and data are latched, and fill_sel is set for fills.
- IDLE -> WRITE on a store win. In WRITE: mem_en=1, mem_wr=1, mem_addr/mem_wdata are the latched values, and wr_done=1. The next state is IDLE.
- IDLE -> FILL on a miss win. The latched base address is addr & 16'hFFF0.
- FILL issue phase: the issue counter k runs 0..WORDS-1 over consecutive cycles. Each cycle drives mem_en=1, mem_wr=0, mem_addr=base+2k. mem_en=0 once k reaches WORDS.
- FILL return phase: each mem_rvalid beat asserts fill_we, with fill_word=beat counter and fill_data=mem_rdata. The beat counter then increments, wrapping 7->0.
- On the WORDS-th beat the state goes to DONE.
- DONE: i_done or d_done pulses according to fill_sel, then the state returns to IDLE. Requests are not sampled in DONE.
- mem_rvalid outside FILL is ignored: no fill_we, and counters are unchanged.
- rst asserted in any state aborts the operation immediately. No done pulse is generated, and the quiet period then applies.

## Timing
- Requests are sampled in IDLE in cycle 0.
- Store: WRITE in cycle 1, memory write and wr_done in cycle 1, IDLE in cycle 2. Occupancy is 2 cycles.
- Fill: reads are issued in cycles 1..WORDS, beats arrive in cycles 1+MEM_LAT..WORDS+MEM_LAT, and the done pulse is in cycle WORDS+MEM_LAT+1. With defaults the done pulse is in cycle 13 and IDLE is in cycle 14.
- Requesters drop their request on the edge after their done pulse. A request still high in IDLE is treated as new.
- Simultaneous requests: the winner per priority is served, and losers wait with their request held. After a D-side completion, a pending i_miss wins the next IDLE cycle unless a D-side request is also high.
- Back-to-back: the minimum gap between consecutive operations is one IDLE cycle.
- Memory must return beats in issue order with exactly MEM_LAT cycles of latency.

## Test plan
- Reset, then i_miss=1 with i_miss_addr=16'h1236 -> busy=1 for 4 cycles. mem_addr then reads 0x1230..0x123E in 8 consecutive cycles, with fill_sel=0 and fill_word 0..7. i_done pulses 13 cycles after the IDLE sample.
- d_wr_req with addr=16'h0040, data=16'hBEEF -> one cycle with mem_en=1, mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, wr_done=1. IDLE the next cycle.
- i_miss, d_miss and d_wr_req all raised in the same cycle -> order of service is write, then D fill, then I fill. Each done pulse occurs exactly once, with correct fill_sel per fill.
- rst asserted in FILL after 3 beats, with the memory model still returning beats -> no fill_we and no done pulse. Stale rvalid during the 4-cycle quiet period is ignored. A following d_miss at 16'h2000 fills cleanly with words 0..7.
- mem_rvalid pulsed while in IDLE or WRITE -> fill_we=0 and the next fill's fill_word starts at 0.
